// File: rtl/ft833_pic_pkg.sv
// ft833_pic_pkg
//   Shared definitions for the FT833 programmable interrupt controller.
//   Holds the register-window offsets, the CTRL bit positions, the 16-bit
//   source vector type and a small priority helper.
//   No ports (package).

package ft833_pic_pkg;

    // One bit per interrupt source; bit 0 is the highest priority
    typedef logic [15:0] pic_src_t;

    // Register window offsets on the 4-bit ad bus
    localparam logic [3:0] PIC_IE_LO   = 4'h0;
    localparam logic [3:0] PIC_IE_HI   = 4'h1;
    localparam logic [3:0] PIC_EDGE_LO = 4'h2;
    localparam logic [3:0] PIC_EDGE_HI = 4'h3;
    localparam logic [3:0] PIC_PEND_LO = 4'h4;
    localparam logic [3:0] PIC_PEND_HI = 4'h5;
    localparam logic [3:0] PIC_VEC     = 4'h6;
    localparam logic [3:0] PIC_CTRL    = 4'h7;
    localparam logic [3:0] PIC_ISR_LO  = 4'h8;
    localparam logic [3:0] PIC_ISR_HI  = 4'h9;

    // CTRL register bit positions
    localparam int CTRL_GEN   = 0;
    localparam int CTRL_NMIRT = 1;

    // Index of the lowest set bit (the highest-priority source).
    // Returns 0 for an empty vector; callers qualify with |v.
    function automatic logic [3:0] pic_lowest_set(input pic_src_t v);
        logic [3:0] idx;
        idx = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (v[i]) begin
                idx = 4'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/ft833_pic_if.sv
// ft833_pic_if
//   CPU register-window bus of the interrupt controller.
//   cs/stb/rw/ad/db_i are driven by the CPU side (master), db_o/db_oe are
//   driven back by the controller (slave). Chip select is decoded outside.
//   Signals:
//     cs    - register-window chip select
//     stb   - one-cycle access strobe (already qualified by vda)
//     rw    - 1 = read, 0 = write
//     ad    - register offset
//     db_i  - write data
//     db_o  - registered read data
//     db_oe - read data valid, one cycle per read

interface ft833_pic_if;
    logic       cs;
    logic       stb;
    logic       rw;
    logic [3:0] ad;
    logic [7:0] db_i;
    logic [7:0] db_o;
    logic       db_oe;

    modport master (
        output cs, stb, rw, ad, db_i,
        input  db_o, db_oe
    );

    modport slave (
        input  cs, stb, rw, ad, db_i,
        output db_o, db_oe
    );
endinterface

// File: rtl/ft833_pic_sync.sv
// ft833_pic_sync
//   Synchronizer for one asynchronous interrupt request line, with a
//   one-cycle pulse on each synchronized 0->1 transition.
//   Ports:
//     clk   - system clock
//     rst_n - asynchronous active-low reset (all flops to 0)
//     d     - raw asynchronous request
//     q     - synchronized level
//     rise  - high for one cycle when q goes from 0 to 1
//   Parameters:
//     SYNC_STAGES - synchronizer depth (2..3)

module ft833_pic_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q,
    output logic rise
);

    logic [SYNC_STAGES-1:0] chain;
    logic                   q_prev;

    // Shift the raw request through the synchronizer chain and keep one
    // extra copy of the synchronized level so a rising edge can be seen.
    // Everything resets to 0, so no edge appears on the first cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain  <= '0;
            q_prev <= 1'b0;
        end else begin
            chain  <= {chain[SYNC_STAGES-2:0], d};
            q_prev <= chain[SYNC_STAGES-1];
        end
    end

    assign q    = chain[SYNC_STAGES-1];
    assign rise = chain[SYNC_STAGES-1] & ~q_prev;

endmodule

// File: rtl/ft833_pic.sv
// ft833_pic
//   Programmable interrupt controller in front of the FT833 CPU irq_n/nmi_n.
//   Up to 16 sources with per-source enable and edge/level mode, fixed
//   priority (source 0 highest), vector readout with acknowledge, and an
//   optional NMI routing of the top implemented source.
//   Ports:
//     clk   - system clock
//     rst_n - asynchronous active-low reset
//     bus   - register window (ft833_pic_if.slave)
//     src   - raw active-high asynchronous requests, bits >= NSRC ignored
//     irq_n - registered maskable interrupt, active-low
//     nmi_n - registered non-maskable interrupt, active-low
//   Parameters:
//     NSRC        - number of implemented sources (1..16)
//     SYNC_STAGES - synchronizer depth per source (2..3)
//   Build option:
//     FT833_PIC_NEST_EN - adds the in-service register ISR with nesting,
//                         EOI on offset-6 writes and ISR readback at 8/9.

module ft833_pic
    import ft833_pic_pkg::*;
#(
    parameter int NSRC        = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    ft833_pic_if.slave      bus,
    input  pic_src_t        src,
    output logic            irq_n,
    output logic            nmi_n
);

    localparam pic_src_t SRC_MASK = pic_src_t'((32'd1 << NSRC) - 32'd1);
    localparam pic_src_t NMI_BIT  = pic_src_t'(32'd1 << (NSRC - 1));

    pic_src_t   sync_lvl;
    pic_src_t   sync_rise;
    pic_src_t   ie_q;
    pic_src_t   edge_q;
    pic_src_t   pend_q;
    pic_src_t   pend_clr;
    pic_src_t   pend_next;
    pic_src_t   nmi_route;
    pic_src_t   svc_allow;
    pic_src_t   cand;
    logic [1:0] ctrl_q;
    logic       acc;
    logic       rd;
    logic       wr;
    logic       vec_any;
    logic [3:0] vec_num;
    logic [7:0] rd_data;
    logic       nmi_hold;

    // One synchronizer per implemented source; unimplemented sources are
    // tied off so they never become pending.
    for (genvar i = 0; i < 16; i++) begin : g_src
        if (i < NSRC) begin : g_impl
            ft833_pic_sync #(
                .SYNC_STAGES(SYNC_STAGES)
            ) u_sync (
                .clk  (clk),
                .rst_n(rst_n),
                .d    (src[i]),
                .q    (sync_lvl[i]),
                .rise (sync_rise[i])
            );
        end else begin : g_tie
            assign sync_lvl[i]  = 1'b0;
            assign sync_rise[i] = 1'b0;
        end
    end

    assign acc = bus.cs & bus.stb;
    assign rd  = acc & bus.rw;
    assign wr  = acc & ~bus.rw;

    // When NMI routing is on, the top source is taken away from the
    // maskable path entirely (irq_n and VEC).
    assign nmi_route = ctrl_q[CTRL_NMIRT] ? NMI_BIT : '0;

`ifdef FT833_PIC_NEST_EN
    pic_src_t isr_q;
    pic_src_t isr_low;

    // Isolate the highest-priority in-service bit; everything strictly
    // above it in priority (lower index) is still allowed to interrupt.
    // With nothing in service, low-1 wraps to all ones.
    assign isr_low   = isr_q & (~isr_q + 16'd1);
    assign svc_allow = isr_low - 16'd1;

    // In-service tracking: a successful VEC read marks the source as
    // in service, an offset-6 write retires the highest-priority one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            isr_q <= '0;
        end else if (rd && bus.ad == PIC_VEC && vec_any) begin
            isr_q <= isr_q | (SRC_MASK & (pic_src_t'(1) << vec_num));
        end else if (wr && bus.ad == PIC_VEC) begin
            isr_q <= isr_q & (isr_q - 16'd1);
        end
    end
`else
    assign svc_allow = '1;
`endif

    assign cand    = pend_q & ie_q & ~nmi_route & svc_allow;
    assign vec_any = |cand;
    assign vec_num = pic_lowest_set(cand);

    // Clear requests for edge latches: a write of ones to PEND, or the
    // acknowledge implied by a VEC read that found a source.
    always_comb begin
        pend_clr = '0;
        if (wr && bus.ad == PIC_PEND_LO) begin
            pend_clr[7:0] = bus.db_i;
        end
        if (wr && bus.ad == PIC_PEND_HI) begin
            pend_clr[15:8] = bus.db_i;
        end
        if (rd && bus.ad == PIC_VEC && vec_any) begin
            pend_clr[vec_num] = 1'b1;
        end
    end

    // Edge bits hold until cleared, with a new edge winning over a clear
    // in the same cycle; level bits simply follow the synchronized input,
    // which also drops any latch left over when EDGE is turned off.
    assign pend_next = SRC_MASK & ((edge_q & ((pend_q & ~pend_clr) | sync_rise))
                                 | (~edge_q & sync_lvl));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q <= '0;
        end else begin
            pend_q <= pend_next;
        end
    end

    // Configuration registers. Unimplemented source bits are masked so
    // they always read back as 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ie_q   <= '0;
            edge_q <= '0;
            ctrl_q <= '0;
        end else if (wr) begin
            case (bus.ad)
                PIC_IE_LO:   ie_q[7:0]    <= bus.db_i & SRC_MASK[7:0];
                PIC_IE_HI:   ie_q[15:8]   <= bus.db_i & SRC_MASK[15:8];
                PIC_EDGE_LO: edge_q[7:0]  <= bus.db_i & SRC_MASK[7:0];
                PIC_EDGE_HI: edge_q[15:8] <= bus.db_i & SRC_MASK[15:8];
                PIC_CTRL:    ctrl_q       <= bus.db_i[1:0];
                default:     ;
            endcase
        end
    end

    // Read-back multiplexer for the register window.
    always_comb begin
        rd_data = 8'h00;
        case (bus.ad)
            PIC_IE_LO:   rd_data = ie_q[7:0];
            PIC_IE_HI:   rd_data = ie_q[15:8];
            PIC_EDGE_LO: rd_data = edge_q[7:0];
            PIC_EDGE_HI: rd_data = edge_q[15:8];
            PIC_PEND_LO: rd_data = pend_q[7:0];
            PIC_PEND_HI: rd_data = pend_q[15:8];
            PIC_VEC:     rd_data = vec_any ? {1'b1, 3'b000, vec_num} : 8'h00;
            PIC_CTRL:    rd_data = {6'b000000, ctrl_q};
`ifdef FT833_PIC_NEST_EN
            PIC_ISR_LO:  rd_data = isr_q[7:0];
            PIC_ISR_HI:  rd_data = isr_q[15:8];
`endif
            default:     rd_data = 8'h00;
        endcase
    end

    // Read data is registered; db_oe is high exactly for the cycle after
    // the read strobe and db_o is driven to zero otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.db_o  <= 8'h00;
            bus.db_oe <= 1'b0;
        end else if (rd) begin
            bus.db_o  <= rd_data;
            bus.db_oe <= 1'b1;
        end else begin
            bus.db_o  <= 8'h00;
            bus.db_oe <= 1'b0;
        end
    end

    // Maskable interrupt output, registered from the current pending,
    // enable and service state gated by GEN.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_n <= 1'b1;
        end else begin
            irq_n <= ~(ctrl_q[CTRL_GEN] & vec_any);
        end
    end

    // NMI pulse: a routed rising edge pulls nmi_n low, nmi_hold keeps it
    // low for one more cycle so the pulse is two clocks wide. A fresh
    // edge restarts the pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            nmi_n    <= 1'b1;
            nmi_hold <= 1'b0;
        end else if (ctrl_q[CTRL_NMIRT] && sync_rise[NSRC-1]) begin
            nmi_n    <= 1'b0;
            nmi_hold <= 1'b1;
        end else if (nmi_hold) begin
            nmi_n    <= 1'b0;
            nmi_hold <= 1'b0;
        end else begin
            nmi_n    <= 1'b1;
            nmi_hold <= 1'b0;
        end
    end

endmodule
